icache_fill_ctrl: RTL and testbench
===================================

Name: icache_fill_ctrl

Overview:
- Direct-mapped instruction cache with a miss/fill state machine; sits directly upstream of the fetch stage.
- Supplies instruction words for the fetch PC on a hit.
- On a miss it raises a stall and fills the whole line from the multi-cycle unified memory.
- The fetch stage uses its stall output the same way as the hazard unit's stall: hold PC and the IF/ID instruction register.

Parameters:
- LINES, 32, number of cache lines (power of 2)
- WORDS, 8, 16-bit words per line (power of 2; line = 2*WORDS bytes)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch stage wants an instruction this cycle
- fetch_addr  in  16  byte address of instruction (bit 0 ignored)
- fetch_instr  out  16  instruction word; valid when fetch_req & ~fetch_stall
- fetch_stall  out  1  miss in progress; fetch must hold PC
- mem_req  out  1  read request to memory, one per cycle max
- mem_addr  out  16  line-aligned word byte address of request
- mem_rsp_valid  in  1  read data returning (in request order, fixed latency ≥1)
- mem_rsp_data  in  16  returned word

Behaviour:
- Address split with defaults: offset = addr[3:1], index = addr[8:4], tag = addr[15:9]. Widths derive from the parameters.
- Storage:
  - data array LINES×WORDS×16
  - tag array LINES×tag width
  - valid bit per line
- Reset (async, rst_n low): all valid bits 0, FSM = IDLE, counters 0. Outputs: mem_req=0, mem_addr=0, fetch_stall=0, fetch_instr=0x0000.
- Hit = fetch_req & valid[index] & tag match. On a hit, fetch_instr = data[index][offset] combinationally (0-cycle latency) and fetch_stall=0.
- fetch_stall = (fetch_req & ~hit) | (state≠IDLE).
- When fetch_req=0 in IDLE: fetch_stall=0 and fetch_instr=0x0000 (reads as NOP-safe).
- FSM states:
  - IDLE: on fetch_req & ~hit, latch line base (tag,index), clear valid[index], reset req_cnt and rsp_cnt, go to FILL.
  - FILL:
    - Requests: mem_req=1 while req_cnt<WORDS. mem_addr = {tag,index,req_cnt,1'b0}. req_cnt++ each cycle, so WORDS requests are issued on consecutive cycles.
    - Responses: each mem_rsp_valid writes mem_rsp_data into data[index][rsp_cnt] and increments rsp_cnt.
    - Completion: when the response with rsp_cnt==WORDS-1 arrives, write the latched tag, set valid[index], go to IDLE.
  - IDLE after fill: the next cycle the same fetch_addr hits, so the miss penalty is WORDS + latency + 1 cycles.
- A fill always completes once started. fetch_req dropping or fetch_addr changing mid-fill (branch flush) does not abort it. The new address is re-evaluated in IDLE.
- mem_rsp_valid in IDLE is ignored (no write).
- A response arriving in the same cycle as a request is legal (latency 1). Both counters update independently.
- Reset mid-fill: the line stays invalid and the FSM returns to IDLE. The memory model is reset by the same rst_n, so no stale responses arrive.
- Counter widths are log2(WORDS)+1; no wrap occurs inside a fill.
- Index aliasing: a miss to a line whose index matches a valid line with a different tag replaces it (clear valid first, so a partially filled line is never hit).

Optional Feature:
- ICACHE_PERF_EN defined:
  - adds outputs perf_hits[15:0] and perf_misses[15:0], saturating at 0xFFFF, reset to 0
  - a hit increments once per cycle with fetch_req & hit & IDLE
  - a miss increments once per IDLE→FILL transition
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cache_pkg:
  - localparams OFFSET_W, INDEX_W, TAG_W derived from LINES/WORDS
  - state enum {IDLE, FILL}
  - address field extraction functions
- One natural sub-module: icache_tag_array (valid + tag storage, async clear on reset, lookup compare). Data array and FSM stay in the top module.

Test Plan:
- Cold miss: reset, fetch_req=1, addr=0x0000, memory latency 4 returns 0x1000+word.
  - Expected: fetch_stall=1 same cycle.
  - mem_req high 8 cycles, addrs 0x0000..0x000E.
  - Stall low 13 cycles after the miss; fetch_instr=0x1000.
- Hit sequence: after the cold fill, addrs 0x0002, 0x000E in consecutive cycles → fetch_instr 0x1001, 0x1007, stall=0, no mem_req.
- Conflict eviction: fill 0x0000, then fetch 0x0200 (same index 0, tag 1).
  - Expected: new fill at 0x0200..0x020E.
  - Afterwards 0x0000 misses again.
- Flush mid-fill: miss on 0x0040, drop fetch_req after 3 cycles, present 0x0080.
  - Expected: fill of 0x0040 completes (8 responses written, valid set).
  - Then a new miss on 0x0080; 0x0040 then hits.
- Reset mid-fill: assert rst_n=0 during the 5th response.
  - Expected: outputs to reset values immediately; line invalid; re-fetch of the same addr misses.
- Latency-1 memory plus ICACHE_PERF_EN: 2 misses and 10 hits give perf_misses=2, perf_hits=10; miss penalty = 10 cycles.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the instruction cache.
// The helpers cover the default geometry (32 lines x 8 words); the top module re-derives its widths from its own parameters.
package cache_pkg;

  localparam int DEF_LINES = 32;
  localparam int DEF_WORDS = 8;
  localparam int ADDR_W    = 16;
  localparam int OFFSET_W  = $clog2(DEF_WORDS);
  localparam int INDEX_W   = $clog2(DEF_LINES);
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W - 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W:1];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W+INDEX_W:OFFSET_W+1];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:ADDR_W-TAG_W];
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tag storage for the direct-mapped instruction cache.
// Valid bits clear asynchronously on reset; the lookup port compares combinationally.
module icache_tag_array #(
  parameter int LINES = 32,
  parameter int TAG_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(LINES)-1:0] i_rd_index,
  input  logic [TAG_W-1:0]         i_rd_tag,
  output logic                     o_hit,
  input  logic                     i_clr,
  input  logic [$clog2(LINES)-1:0] i_clr_index,
  input  logic                     i_set,
  input  logic [$clog2(LINES)-1:0] i_set_index,
  input  logic [TAG_W-1:0]         i_set_tag
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_clr) begin
      r_valid[i_clr_index] <= 1'b0;
    end else if (i_set) begin
      r_valid[i_set_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_set) r_tag[i_set_index] <= i_set_tag;
  end

  assign o_hit = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with whole-line miss fill from multi-cycle memory.
// Optional ICACHE_PERF_EN adds saturating perf_hits / perf_misses counters.
//
// state | meaning
// IDLE  | serving hits; a miss latches the line base and clears its valid bit
// FILL  | issuing WORDS reads back-to-back and writing responses in order
module icache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic [15:0] fetch_instr,
  output logic        fetch_stall,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [15:0] mem_rsp_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [15:0] perf_hits,
  output logic [15:0] perf_misses
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TG_W  = 16 - IDX_W - OFF_W - 1;
  localparam int CNT_W = OFF_W + 1;

  state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_index;
  logic [TG_W-1:0]   r_tag;
  logic [CNT_W-1:0]  r_req_cnt, r_rsp_cnt;
  logic [15:0]       r_data [LINES*WORDS];

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TG_W-1:0]   w_tag;
  logic              w_lookup_hit, w_hit, w_start, w_done, w_rsp_wr, w_last;

  assign w_off    = fetch_addr[OFF_W:1];
  assign w_idx    = fetch_addr[OFF_W+IDX_W:OFF_W+1];
  assign w_tag    = fetch_addr[15:16-TG_W];
  assign w_hit    = fetch_req & w_lookup_hit;
  assign w_rsp_wr = (r_state == FILL) & mem_rsp_valid;
  assign w_last   = w_rsp_wr & (r_rsp_cnt == {1'b0, {OFF_W{1'b1}}});

  icache_tag_array #(.LINES(LINES), .TAG_W(TG_W)) u_tags (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_index  (w_idx),
    .i_rd_tag    (w_tag),
    .o_hit       (w_lookup_hit),
    .i_clr       (w_start),
    .i_clr_index (w_idx),
    .i_set       (w_done),
    .i_set_index (r_index),
    .i_set_tag   (r_tag)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (fetch_req && !w_lookup_hit) begin
        w_start     = 1'b1;
        w_state_nxt = FILL;
      end
      FILL: if (w_last) begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request counter's MSB marks that all WORDS reads have been issued.
  assign mem_req     = (r_state == FILL) & ~r_req_cnt[OFF_W];
  assign mem_addr    = mem_req ? {r_tag, r_index, r_req_cnt[OFF_W-1:0], 1'b0} : 16'h0000;
  // Gated by rst_n so outputs read as idle while reset is held with fetch_req high.
  assign fetch_stall = rst_n & ((fetch_req & ~w_lookup_hit) | (r_state != IDLE));
  assign fetch_instr = ((r_state == IDLE) && w_hit) ? r_data[{w_idx, w_off}] : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_tag     <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_index   <= w_idx;
        r_tag     <= w_tag;
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
      end else begin
        if (mem_req)  r_req_cnt <= r_req_cnt + 1'b1;
        if (w_rsp_wr) r_rsp_cnt <= r_rsp_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rsp_wr) r_data[{r_index, r_rsp_cnt[OFF_W-1:0]}] <= mem_rsp_data;
  end

`ifdef ICACHE_PERF_EN
  logic [15:0] r_perf_hits, r_perf_misses;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
    end else begin
      if ((r_state == IDLE) && w_hit && (r_perf_hits != 16'hFFFF))
        r_perf_hits <= r_perf_hits + 1'b1;
      if (w_start && (r_perf_misses != 16'hFFFF))
        r_perf_misses <= r_perf_misses + 1'b1;
    end
  end

  assign perf_hits   = r_perf_hits;
  assign perf_misses = r_perf_misses;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed testbench for icache_fill_ctrl with a fixed-latency memory model.
// Define ICACHE_PERF_EN to also check the performance counters.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0000;
  logic [15:0] fetch_instr;
  logic        fetch_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = 16'h0000;
`ifdef ICACHE_PERF_EN
  logic [15:0] perf_hits, perf_misses;
`endif

  always #5 clk = ~clk;

  icache_fill_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_instr   (fetch_instr),
    .fetch_stall   (fetch_stall),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hits     (perf_hits),
    .perf_misses   (perf_misses)
`endif
  );

  // Memory model: word at byte address a reads as 0x1000 + a/2, returned lat cycles after the request.
  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  int          lat = 4;
  int          cyc = 0;
  int          rsp_seen = 0;
  rsp_t        pend[$];
  logic [15:0] req_log[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= 16'h0000;
    end else begin
      cyc++;
      if (mem_req) begin
        pend.push_back('{due: cyc + lat - 1, data: 16'h1000 + {1'b0, mem_addr[15:1]}});
        req_log.push_back(mem_addr);
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= pend[0].data;
        void'(pend.pop_front());
        rsp_seen++;
      end else begin
        mem_rsp_valid <= 1'b0;
        mem_rsp_data  <= 16'h0000;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] a);
    @(posedge clk);
    #1;
    fetch_req  = r;
    fetch_addr = a;
    @(negedge clk);
  endtask

  task automatic check_log(input string nm, input logic [15:0] a);
    int bad;
    logic [15:0] base;
    bad  = 0;
    base = a & 16'hFFF0;
    chk({nm, "_nreq"}, req_log.size(), 8);
    for (int i = 0; i < req_log.size(); i++)
      if (req_log[i] !== base + 16'(2 * i)) bad++;
    chk({nm, "_addrs"}, bad, 0);
  endtask

  task automatic miss_fill(input logic [15:0] a, input int pen, input string nm);
    int n;
    req_log.delete();
    drive(1'b1, a);
    chk({nm, "_stall"}, fetch_stall, 1);
    n = 0;
    while (fetch_stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_penalty"}, n, pen);
    check_log(nm, a);
    chk({nm, "_instr"}, fetch_instr, 16'h1000 + {1'b0, a[15:1]});
  endtask

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        stall;
    logic [15:0] instr;
  } vec_t;

  vec_t hv[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s;
    hv[0] = '{1'b1, 16'h0002, 1'b0, 16'h1001};
    hv[1] = '{1'b1, 16'h000E, 1'b0, 16'h1007};
    hv[2] = '{1'b0, 16'h000E, 1'b0, 16'h0000};
    hv[3] = '{1'b1, 16'h0000, 1'b0, 16'h1000};

    // Reset values, with fetch_req held high to exercise output gating
    fetch_req = 1'b1;
    #22;
    chk("rst_stall", fetch_stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_instr", fetch_instr, 16'h0000);
`ifdef ICACHE_PERF_EN
    chk("rst_perf_hits", perf_hits, 0);
    chk("rst_perf_misses", perf_misses, 0);
`endif
    fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_noreq_stall", fetch_stall, 0);

    miss_fill(16'h0000, 13, "cold");

    for (int i = 0; i < 4; i++) begin
      req_log.delete();
      drive(hv[i].req, hv[i].addr);
      chk($sformatf("hit%0d_stall", i), fetch_stall, hv[i].stall);
      chk($sformatf("hit%0d_instr", i), fetch_instr, hv[i].instr);
      chk($sformatf("hit%0d_mem_req", i), mem_req, 0);
    end

    miss_fill(16'h0200, 13, "evict");
    miss_fill(16'h0000, 13, "refill");

    // Branch flush mid-fill: the fill of 0x0040 must still complete
    req_log.delete();
    drive(1'b1, 16'h0040);
    chk("flush_miss_stall", fetch_stall, 1);
    drive(1'b1, 16'h0040);
    drive(1'b1, 16'h0040);
    drive(1'b0, 16'h0080);
    chk("flush_hold_stall", fetch_stall, 1);
    n = 0;
    while (fetch_stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("flush_done", fetch_stall, 0);
    check_log("flush", 16'h0040);
    miss_fill(16'h0080, 13, "after_flush");
    drive(1'b1, 16'h0040);
    chk("flush_hit_stall", fetch_stall, 0);
    chk("flush_hit_instr", fetch_instr, 16'h1020);
    drive(1'b1, 16'h004E);
    chk("flush_hit2_instr", fetch_instr, 16'h1027);

    // Reset during the 5th response
    s = rsp_seen;
    drive(1'b1, 16'h00C0);
    chk("rmid_miss_stall", fetch_stall, 1);
    n = 0;
    while (rsp_seen != s + 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rmid_reached5", (rsp_seen == s + 5), 1);
    rst_n = 1'b0;
    #1;
    chk("rmid_stall", fetch_stall, 0);
    chk("rmid_mem_req", mem_req, 0);
    chk("rmid_mem_addr", mem_addr, 16'h0000);
    chk("rmid_instr", fetch_instr, 16'h0000);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    miss_fill(16'h00C0, 13, "post_rst");

    // Latency-1 memory: penalty WORDS+2; 2 misses and 10 hit cycles
    drive(1'b0, 16'h0000);
    rst_n = 1'b0;
    lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    miss_fill(16'h0000, 10, "lat1_a");
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h0002);
    miss_fill(16'h0200, 10, "lat1_b");
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h0204);
    chk("lat1_hit_instr", fetch_instr, 16'h1102);
    drive(1'b0, 16'h0000);
`ifdef ICACHE_PERF_EN
    chk("perf_hits", perf_hits, 10);
    chk("perf_misses", perf_misses, 2);
`endif
    chk("final_stall", fetch_stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
